// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo PWM path.
// Angle width must match the upstream up/down reference-angle counter.
package servo_pkg;

  localparam int ANGLE_W     = 9;
  localparam int TICK_DIV    = 139;
  localparam int MIN_TICKS   = 360;
  localparam int FRAME_TICKS = 7200;
  localparam int ANGLE_MAX   = 360;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  function automatic logic [ANGLE_W-1:0] clamp_angle(
    input logic [ANGLE_W-1:0] a,
    input logic [ANGLE_W-1:0] a_max
  );
    return (a > a_max) ? a_max : a;
  endfunction

endpackage

// File: rtl/servo_tick_prescaler.sv
// Divides the clock down to one angle-unit tick every TICK_DIV clocks.
// Tick is combinational off the count; clear has priority over run.
module servo_tick_prescaler #(
  parameter int TICK_DIV = servo_pkg::TICK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_tick
);

  localparam logic [7:0] P_LAST = 8'(TICK_DIV - 1);

  logic [7:0] r_presc;

  assign o_tick = i_run && (r_presc == P_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= 8'd0;
    end else if (i_clr) begin
      r_presc <= 8'd0;
    end else if (i_run) begin
      r_presc <= o_tick ? 8'd0 : r_presc + 8'd1;
    end
  end

endmodule

// File: rtl/servo_pwm_generator.sv
// Servo frame generator: high for (MIN_TICKS+angle) ticks, frame FRAME_TICKS ticks.
// Start latency one clock from ENA; angle is latched only on the frame-start edge.
module servo_pwm_generator
  import servo_pkg::*;
#(
  parameter int TICK_DIV    = servo_pkg::TICK_DIV,
  parameter int MIN_TICKS   = servo_pkg::MIN_TICKS,
  parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS,
  parameter int ANGLE_MAX   = servo_pkg::ANGLE_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ena,
  input  logic [ANGLE_W-1:0] i_angle,
  output logic               o_pwm,
  output logic               o_frame_start,
  output logic [ANGLE_W-1:0] o_angle_lat
);

  localparam logic [12:0]        F_LAST = 13'(FRAME_TICKS - 1);
  localparam logic [9:0]         MIN_W  = 10'(MIN_TICKS);
  localparam logic [ANGLE_W-1:0] A_MAX  = ANGLE_W'(ANGLE_MAX);

  state_t             r_state;
  logic [12:0]        r_ftick;
  logic [ANGLE_W-1:0] r_angle_lat;
  logic               r_pwm;
  logic               r_frame_start;

  logic       w_tick;
  logic       w_run;
  logic       w_frame_end;
  logic       w_start;
  logic [9:0] w_hi_end;

  assign w_run       = (r_state != ST_IDLE);
  assign w_frame_end = (r_state == ST_LOW) && w_tick && (r_ftick == F_LAST);
  assign w_start     = i_ena && ((r_state == ST_IDLE) || w_frame_end);
  assign w_hi_end    = MIN_W + {1'b0, r_angle_lat} - 10'd1;

  servo_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_ftick       <= 13'd0;
      r_angle_lat   <= '0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_start) begin
        // Frame start covers both the IDLE launch and the seamless restart.
        r_state       <= ST_HIGH;
        r_ftick       <= 13'd0;
        r_angle_lat   <= clamp_angle(i_angle, A_MAX);
        r_pwm         <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_pwm <= 1'b0;
          end
          ST_HIGH: begin
            if (w_tick) begin
              r_ftick <= r_ftick + 13'd1;
              if (r_ftick == {3'b000, w_hi_end}) begin
                r_state <= ST_LOW;
                r_pwm   <= 1'b0;
              end
            end
          end
          ST_LOW: begin
            if (w_frame_end) begin
              r_state <= ST_IDLE;
              r_ftick <= 13'd0;
              r_pwm   <= 1'b0;
            end else if (w_tick) begin
              r_ftick <= r_ftick + 13'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_pwm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_pwm         = r_pwm;
  assign o_frame_start = r_frame_start;
  assign o_angle_lat   = r_angle_lat;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Bench for servo_pwm_generator at reduced timing parameters.
module tb_servo_pwm_generator;

  localparam int TD    = 4;
  localparam int MINT  = 10;
  localparam int FT    = 40;
  localparam int AMAX  = 20;
  localparam int FRAME = FT * TD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [8:0] angle = 9'd0;
  logic       pwm;
  logic       fs;
  logic [8:0] lat;

  int total = 0;
  int bad = 0;

  servo_pwm_generator #(
    .TICK_DIV    (TD),
    .MIN_TICKS   (MINT),
    .FRAME_TICKS (FT),
    .ANGLE_MAX   (AMAX)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_angle       (angle),
    .o_pwm         (pwm),
    .o_frame_start (fs),
    .o_angle_lat   (lat)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int a);
    return (a > AMAX) ? AMAX : a;
  endfunction

  // Reference: clocks elapsed since the current frame began.
  bit m_run;
  int m_cnt;
  int m_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_lat = 0;
    end else if (m_run) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == FRAME) begin
        if (ena) begin
          m_cnt = 0;
          m_lat = clampi(int'(angle));
        end else begin
          m_run = 1'b0;
        end
      end
    end else if (ena) begin
      m_run = 1'b1;
      m_cnt = 0;
      m_lat = clampi(int'(angle));
    end
  end

  task automatic do_reset();
    ena   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_frame(output int hi, output int per, output bit ok);
    hi = 0;
    per = 0;
    if (fs) ok = 1'b1;
    else wait_fs(ok);
    if (!ok) return;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pwm) hi++;
      per++;
      @(negedge clk);
      if (fs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int hits;
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pwm !== 1'b0 || fs !== 1'b0 || lat !== 9'd0) begin
      bad++;
      $display("FAIL reset_state: pwm=%b fs=%b lat=%0d, want 0 0 0", pwm, fs, lat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    angle = 9'd15;
    ena   = 1'b1;
    @(negedge clk);
    total++;
    if (pwm !== 1'b1 || fs !== 1'b1 || lat !== 9'd15) begin
      bad++;
      $display("FAIL start_latency: pwm=%b fs=%b lat=%0d, want 1 1 15", pwm, fs, lat);
    end
    @(negedge clk);
    total++;
    if (fs !== 1'b0) begin
      bad++;
      $display("FAIL fs_one_clock: fs=%b, want 0", fs);
    end
    repeat (20) @(negedge clk);
    total++;
    if (pwm !== 1'b1) begin
      bad++;
      $display("FAIL mid_pulse: pwm=%b, want 1", pwm);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pwm !== 1'b0 || fs !== 1'b0 || lat !== 9'd0) begin
      bad++;
      $display("FAIL async_reset: pwm=%b fs=%b lat=%0d, want 0 0 0", pwm, fs, lat);
    end
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm !== 1'b0 || fs !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL idle_after_reset: active clocks=%0d, want 0", hits);
    end
  endtask

  task automatic test_width();
    int angs[5] = '{0, 20, 25, 10, 31};
    int hi, per;
    bit ok;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      angle = 9'(angs[k]);
      ena   = 1'b1;
      wait_fs(ok);
      total++;
      if (!ok || int'(lat) != clampi(angs[k])) begin
        bad++;
        $display("FAIL width_lat a=%0d: lat=%0d ok=%b, want %0d", angs[k], lat, ok, clampi(angs[k]));
      end
      measure_frame(hi, per, ok);
      total++;
      if (!ok || hi != (MINT + clampi(angs[k])) * TD) begin
        bad++;
        $display("FAIL width_high a=%0d: high=%0d ok=%b, want %0d", angs[k], hi, ok, (MINT + clampi(angs[k])) * TD);
      end
      total++;
      if (!ok || per != FRAME || per - hi != FRAME - (MINT + clampi(angs[k])) * TD) begin
        bad++;
        $display("FAIL width_period a=%0d: period=%0d low=%0d, want %0d", angs[k], per, per - hi, FRAME);
      end
    end
  endtask

  task automatic test_mid_angle();
    int hi1, per1, hi2, per2;
    bit ok, ok1, ok2;
    do_reset();
    angle = 9'd5;
    ena   = 1'b1;
    wait_fs(ok);
    fork
      measure_frame(hi1, per1, ok1);
      begin
        repeat (10) @(negedge clk);
        angle = 9'd18;
      end
    join
    total++;
    if (!ok || !ok1 || hi1 != 60 || per1 != FRAME) begin
      bad++;
      $display("FAIL mid_angle_cur: high=%0d period=%0d, want 60 %0d", hi1, per1, FRAME);
    end
    total++;
    if (lat !== 9'd18) begin
      bad++;
      $display("FAIL mid_angle_lat: lat=%0d, want 18", lat);
    end
    measure_frame(hi2, per2, ok2);
    total++;
    if (!ok2 || hi2 != 112) begin
      bad++;
      $display("FAIL mid_angle_next: high=%0d, want 112", hi2);
    end
  endtask

  task automatic test_ena_drop();
    int hi, nfs;
    bit ok;
    do_reset();
    angle = 9'd10;
    ena   = 1'b1;
    wait_fs(ok);
    hi = 0;
    nfs = 0;
    for (int t = 0; t < 400; t++) begin
      if (pwm) hi++;
      if (t > 0 && fs) nfs++;
      if (t == 100) ena = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok || hi != 80 || nfs != 0 || pwm !== 1'b0) begin
      bad++;
      $display("FAIL ena_drop: high=%0d extra_fs=%0d pwm=%b, want 80 0 0", hi, nfs, pwm);
    end
    ena = 1'b1;
    @(negedge clk);
    total++;
    if (pwm !== 1'b1 || fs !== 1'b1) begin
      bad++;
      $display("FAIL ena_restart: pwm=%b fs=%b, want 1 1", pwm, fs);
    end
  endtask

  task automatic test_ena_boundary();
    int nfs, first;
    bit ok;
    do_reset();
    angle = 9'd3;
    ena   = 1'b1;
    wait_fs(ok);
    nfs = 0;
    first = -1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0 && fs) begin
        nfs++;
        if (first < 0) first = t;
      end
      case (t)
        100: ena = 1'b0;
        120: ena = 1'b1;
        130: ena = 1'b0;
        159: ena = 1'b1;
        160: ena = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    total++;
    if (!ok || nfs != 1 || first != FRAME) begin
      bad++;
      $display("FAIL ena_boundary: starts=%0d first=%0d, want 1 %0d", nfs, first, FRAME);
    end
  endtask

  task automatic test_random();
    bit e_pwm, e_fs;
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      e_pwm = m_run && (m_cnt < (MINT + m_lat) * TD);
      e_fs  = m_run && (m_cnt == 0);
      total++;
      if (pwm !== e_pwm || fs !== e_fs || int'(lat) != m_lat) begin
        bad++;
        $display("FAIL random c=%0d: pwm=%b fs=%b lat=%0d, want %b %b %0d", c, pwm, fs, lat, e_pwm, e_fs, m_lat);
      end
      if ($urandom_range(0, 299) == 0) ena = ~ena;
      angle = 9'($urandom_range(0, 31));
    end
  endtask

  initial begin
    test_reset();
    test_width();
    test_mid_angle();
    test_ena_drop();
    test_ena_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_generator.md
# servo_pwm_generator

Downstream stage of the 9-bit up/down reference-angle counter. Converts the counter's angle value into the servo control waveform: a fixed-period frame (≈20 ms) whose high pulse is 1 ms plus one angle unit per degree. The input angle is sampled only at frame boundaries, so counter steps never produce runt or stretched pulses.

## Interface
- TICK_DIV, 139: clocks per angle-unit tick (50 MHz → 2.78 µs/unit, 1 ms/360 units).
- MIN_TICKS, 360: pulse-width floor in ticks, reached at angle 0.
- FRAME_TICKS, 7200: frame length in ticks (≈20.016 ms). Required: MIN_TICKS+ANGLE_MAX < FRAME_TICKS.
- ANGLE_MAX, 360: clamp ceiling for the angle input.
- CLK  in  1  single system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ENA  in  1  run enable; sampled only in IDLE and at end of frame.
- ANGLE  in  9  reference angle from the up/down counter, unsigned.
- PWM  out  1  servo drive, registered.
- FRAME_START  out  1  one-clock pulse, coincident with the first high clock of each frame.
- ANGLE_LAT  out  9  clamped angle used by the current frame.

## Operation
- Prescaler presc counts 0..TICK_DIV-1 (8 bits). tick = (presc==TICK_DIV-1). It counts only outside IDLE and is zeroed when a frame starts.
- Frame counter ftick counts 0..FRAME_TICKS-1 (13 bits). It increments on tick and is zeroed when a frame starts.
- Clamp: clamp(a) = (a > ANGLE_MAX) ? ANGLE_MAX : a. The comparison is 9-bit unsigned.
- FSM states:
  - IDLE: PWM=0. If ENA=1, start a frame and go to HIGH.
  - HIGH: PWM=1. On tick with ftick == MIN_TICKS+ANGLE_LAT-1, go to LOW. The sum is 10-bit unsigned, with no overflow for legal parameters.
  - LOW: PWM=0. On tick with ftick == FRAME_TICKS-1: if ENA=1, start a new frame and stay in the HIGH path; else go to IDLE.
- Frame start, in one edge: ANGLE_LAT←clamp(ANGLE), presc←0, ftick←0, state←HIGH, PWM←1, FRAME_START←1.
- FRAME_START is 0 on every other clock.
- Resulting waveform:
  - High time is exactly (MIN_TICKS+ANGLE_LAT)·TICK_DIV clocks.
  - Frame is exactly FRAME_TICKS·TICK_DIV clocks.
  - Back-to-back frames have no gap clocks.
- Boundary rules:
  - ANGLE changes mid-frame are ignored until the next frame start.
  - ENA falling mid-frame: the current frame completes fully, then IDLE.
  - ENA pulses shorter than a frame while running have no effect unless present at the frame-end tick.
  - ANGLE=0 gives the minimum pulse. ANGLE ≥ ANGLE_MAX gives the maximum pulse.
- Reset (RST=0, asynchronous, any time including mid-pulse):
  - state=IDLE, PWM=0, FRAME_START=0, ANGLE_LAT=0, presc=0, ftick=0.
  - After RST releases, the first frame can start on the first edge that sees ENA=1.

## Timing
- Latency: ENA=1 sampled at edge k in IDLE → PWM=1 and FRAME_START=1 after edge k.
- Pulse end: PWM falls on the edge where the terminal tick occurs. Frame restart likewise happens on the terminal tick edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- ANGLE is captured on one edge only, the frame-start edge. It needs setup to CLK but no hold across the frame.

## Structure
- Package servo_pkg holds:
  - the state enum (IDLE, HIGH, LOW);
  - default constants TICK_DIV, MIN_TICKS, FRAME_TICKS, ANGLE_MAX;
  - the ANGLE_W=9 width constant shared with the up/down counter.
- Sub-module servo_tick_prescaler: parameter TICK_DIV; ports CLK, RST, CLR, RUN, TICK. The FSM, clamp and frame counter stay in the top module.

## Test plan
- Reset mid-pulse: assert RST=0 while PWM=1 → PWM, FRAME_START and ANGLE_LAT are 0 immediately, without waiting for an edge, and stay IDLE while ENA=0.
- Default parameters, ANGLE=180, ENA=1 → PWM high 75060 clocks, period 1000800 clocks, FRAME_START once per period, ANGLE_LAT=180.
- ANGLE=0 → high 50040 clocks. ANGLE=400 → ANGLE_LAT=360, high 100080 clocks.
- ANGLE steps 20→340 mid-pulse → current frame high 52820 clocks; next frame high 97300 clocks.
- ENA drops in LOW phase → frame ends at exactly 1000800 clocks, then PWM stays 0. ENA raised again → PWM and FRAME_START high on the next edge.
- Reduced parameters TICK_DIV=4, MIN_TICKS=10, FRAME_TICKS=40, ANGLE_MAX=20, ANGLE=20, ENA held → high 120 and low 40 clocks repeating, with no gap clocks between frames.
